// File: rtl/lsu_mem_bridge_pkg.sv
// Shared load/store definitions: FSM states, func3 encodings and the latched request record.
package lsu_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Word address is kept outside the record so the record stays width-independent.
    typedef struct packed {
        logic        we;
        logic [2:0]  func3;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_mem_bridge_align.sv
// Byte-lane steering for the LSU bridge: store byte enables and replication,
// load lane extraction with sign/zero extension, and access legality flags.
module lsu_align
    import lsu_mem_bridge_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic        is_store_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wr_data_i,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ram_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Request side: legality first, alignment only for legal encodings.
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wr_data_i;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (func3_i)
            F3_B, F3_BU: begin
                if (is_store_i && (func3_i == F3_BU)) begin
                    illegal_o = 1'b1;
                end else begin
                    be_o    = 4'b0001 << off_i;
                    wdata_o = {4{wr_data_i[7:0]}};
                end
            end
            F3_H, F3_HU: begin
                if (is_store_i && (func3_i == F3_HU)) begin
                    illegal_o = 1'b1;
                end else begin
                    be_o       = 4'b0011 << {off_i[1], 1'b0};
                    wdata_o    = {2{wr_data_i[15:0]}};
                    misalign_o = off_i[0];
                end
            end
            F3_W: begin
                be_o       = 4'b1111;
                misalign_o = |off_i;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // Response side: pick the lane named by the latched offset and extend it.
    always_comb begin
        ld_byte_s = 8'h00;
        ld_half_s = 16'h0000;
        ld_data_o = ram_rdata_i;
        case (ld_off_i)
            2'd0:    ld_byte_s = ram_rdata_i[7:0];
            2'd1:    ld_byte_s = ram_rdata_i[15:8];
            2'd2:    ld_byte_s = ram_rdata_i[23:16];
            default: ld_byte_s = ram_rdata_i[31:24];
        endcase
        if (ld_off_i[1]) begin
            ld_half_s = ram_rdata_i[31:16];
        end else begin
            ld_half_s = ram_rdata_i[15:0];
        end
        case (ld_func3_i)
            F3_B:    ld_data_o = {{24{ld_byte_s[7]}}, ld_byte_s};
            F3_BU:   ld_data_o = {24'h000000, ld_byte_s};
            F3_H:    ld_data_o = {{16{ld_half_s[15]}}, ld_half_s};
            F3_HU:   ld_data_o = {16'h0000, ld_half_s};
            default: ld_data_o = ram_rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// MEM-stage load/store bridge to a variable-latency word RAM: request/grant/response
// handshake, pipeline stall, and error/timeout reporting.
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  stall,
    output logic                  misalign,
    output logic                  access_err,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [DM_ADDRESS-3:0] ram_addr,
    output logic [3:0]            ram_be,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic                  ram_gnt,
    input  logic                  ram_rvalid,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e            state_q, state_d;
    lsu_req_t              req_q, req_d;
    logic [DM_ADDRESS-3:0] waddr_q, waddr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  misalign_q, misalign_d;
    logic                  err_q, err_d;

    logic [3:0]            be_s;
    logic [31:0]           wdata_s;
    logic [31:0]           ld_data_s;
    logic                  misalign_s;
    logic                  illegal_s;
    logic                  access_s;
    logic                  timeout_s;

    lsu_align u_align (
        .func3_i     (func3),
        .is_store_i  (mem_write),
        .off_i       (addr[1:0]),
        .wr_data_i   (wr_data),
        .ld_func3_i  (req_q.func3),
        .ld_off_i    (req_q.off),
        .ram_rdata_i (ram_rdata),
        .be_o        (be_s),
        .wdata_o     (wdata_s),
        .ld_data_o   (ld_data_s),
        .misalign_o  (misalign_s),
        .illegal_o   (illegal_s)
    );

    assign access_s  = mem_read | mem_write;
    assign timeout_s = (cnt_q >= TO_LAST);

    // Next-state, latch capture, timeout counting and stall.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        waddr_d    = waddr_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        misalign_d = 1'b0;
        err_d      = 1'b0;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!access_s) begin
                    state_d = IDLE;
                end else if (illegal_s) begin
                    err_d = 1'b1;
                end else if (misalign_s) begin
                    misalign_d = 1'b1;
                end else begin
                    stall       = 1'b1;
                    req_d.we    = mem_write;
                    req_d.func3 = func3;
                    req_d.off   = addr[1:0];
                    req_d.be    = be_s;
                    req_d.wdata = wdata_s;
                    waddr_d     = addr[DM_ADDRESS-1:2];
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (ram_gnt) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = req_q.we ? DONE : WAIT;
                end else if (timeout_s) begin
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (ram_rvalid) begin
                    rd_data_d = ld_data_s;
                    state_d   = DONE;
                end else if (timeout_s) begin
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latches, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            waddr_q    <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
        end
    end

    assign ram_req    = (state_q == REQ);
    assign ram_we     = ram_req & req_q.we;
    assign ram_be     = ram_req ? req_q.be : 4'b0000;
    assign ram_addr   = waddr_q;
    assign ram_wdata  = req_q.wdata;
    assign rd_data    = rd_data_q;
    assign misalign   = misalign_q;
    assign access_err = err_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Randomized bench for lsu_mem_bridge against a transaction-level reference model.
module tb_lsu_mem_bridge;

    localparam int TO    = 16;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic [31:0] rd_data;
    logic        stall;
    logic        misalign;
    logic        access_err;
    logic        ram_req;
    logic        ram_we;
    logic [6:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_gnt;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    lsu_mem_bridge #(.DATA_W(32), .DM_ADDRESS(9), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wr_data    (wr_data),
        .func3      (func3),
        .rd_data    (rd_data),
        .stall      (stall),
        .misalign   (misalign),
        .access_err (access_err),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_be     (ram_be),
        .ram_wdata  (ram_wdata),
        .ram_gnt    (ram_gnt),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit f3_legal(input bit is_ld, input logic [2:0] f3);
        if (is_ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        int          sz;
        logic [31:0] mask;
        logic [31:0] raw;
        sz   = acc_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        raw  = (w >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && raw[8*sz-1]) raw = raw | ~mask;
        return raw;
    endfunction

    function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return {24'h0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    // Called and returns at #1 after a rising edge with the DUT in IDLE.
    task automatic run_access(input bit is_ld, input logic [8:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, input int g, input int r,
                              input logic [31:0] rdat, input bit gap);
        bit   legal, mis, ok, tmo, exp_req;
        int   sz, busy, stalls, hi;
        logic [3:0] exp_be;
        sz     = acc_size(f3);
        legal  = f3_legal(is_ld, f3);
        mis    = legal && ((a % sz) != 0);
        ok     = legal && !mis;
        tmo    = ok && (g >= TO || (is_ld && (g + r + 2) > TO));
        busy   = tmo ? TO : (g + 1 + (is_ld ? r + 1 : 0));
        hi     = (g + 1 < TO) ? g + 1 : TO;
        exp_be = 4'(((1 << sz) - 1) << a[1:0]);
        mem_read  = is_ld;
        mem_write = !is_ld;
        addr      = a;
        wr_data   = wd;
        func3     = f3;
        stalls    = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ram_gnt    = (cyc == g + 1);
            ram_rvalid = is_ld && (cyc == g + 2 + r);
            ram_rdata  = ram_rvalid ? rdat : $urandom();
            @(negedge clk);
            exp_req = ok && cyc >= 1 && cyc <= hi;
            check_val("ram_req", ram_req, exp_req);
            if (!stall) break;
            stalls++;
            if (exp_req) begin
                check_val("ram_addr", ram_addr, a[8:2]);
                check_val("ram_be", ram_be, exp_be);
                check_val("ram_we", ram_we, !is_ld);
                if (!is_ld) check_val("ram_wdata", ram_wdata, ref_wdata(sz, wd));
            end
            @(posedge clk);
            #1;
        end
        ram_gnt    = 1'b0;
        ram_rvalid = 1'b0;
        check_val("stall_cycles", stalls, ok ? 1 + busy : 0);
        if (ok) begin
            if (tmo) model_rd = 32'h0;
            else if (is_ld) model_rd = ref_load(f3, a[1:0], rdat);
            check_val("rd_data_done", rd_data, model_rd);
            check_val("access_err_done", access_err, tmo);
            check_val("misalign_done", misalign, 1'b0);
            @(posedge clk);
            #1;
            if (gap) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                @(negedge clk);
                check_val("rd_data_hold", rd_data, model_rd);
                check_val("access_err_idle", access_err, 1'b0);
                check_val("ram_req_idle", ram_req, 1'b0);
                @(posedge clk);
                #1;
            end
        end else begin
            check_val("rd_data_err0", rd_data, model_rd);
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            check_val("misalign_pulse", misalign, mis);
            check_val("access_err_pulse", access_err, !legal);
            check_val("ram_req_err", ram_req, 1'b0);
            check_val("stall_err", stall, 1'b0);
            check_val("rd_data_err1", rd_data, model_rd);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit   ld;
        int   g, r;
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 9'h000;
        wr_data    = 32'h0;
        func3      = 3'b000;
        ram_gnt    = 1'b0;
        ram_rvalid = 1'b0;
        ram_rdata  = 32'h0;
        model_rd   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rd_data", rd_data, 32'h0);
        check_val("rst_outputs", {30'h0, misalign, access_err}, 32'h0);
        check_val("rst_ram_req", {30'h0, ram_req, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_access(1'b0, 9'h010, 32'hDEADBEEF, 3'd2, 0, 0, 32'h0, 1'b1);
        run_access(1'b0, 9'h013, 32'h000000A5, 3'd0, 0, 0, 32'h0, 1'b1);
        run_access(1'b1, 9'h022, 32'h0, 3'd0, 0, 0, 32'h1280FF00, 1'b0);
        run_access(1'b1, 9'h022, 32'h0, 3'd4, 0, 0, 32'h1280FF00, 1'b0);
        run_access(1'b1, 9'h022, 32'h0, 3'd1, 0, 0, 32'h1280FF00, 1'b1);
        run_access(1'b1, 9'h006, 32'h0, 3'd2, 0, 0, 32'h0, 1'b1);
        run_access(1'b1, 9'h020, 32'h0, 3'd3, 0, 0, 32'h0, 1'b1);
        run_access(1'b0, 9'h021, 32'h1234, 3'd5, 0, 0, 32'h0, 1'b1);
        run_access(1'b1, 9'h030, 32'h0, 3'd2, NEVER, 0, 32'h0, 1'b1);
        run_access(1'b1, 9'h04C, 32'h0, 3'd5, 1, 2, 32'hBEEF8001, 1'b0);
        run_access(1'b1, 9'h034, 32'h0, 3'd2, 2, NEVER, 32'h0, 1'b1);
        run_access(1'b0, 9'h035, 32'h0000CAFE, 3'd1, 0, 0, 32'h0, 1'b1);
        run_access(1'b0, 9'h036, 32'h0000CAFE, 3'd1, 3, 0, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            ld = ($urandom_range(0, 1) == 1);
            g  = $urandom_range(0, 4);
            r  = $urandom_range(0, 4);
            if ($urandom_range(0, 19) == 0) g = NEVER;
            else if ($urandom_range(0, 19) == 0) r = NEVER;
            run_access(ld, 9'($urandom()), $urandom(), 3'($urandom_range(0, 7)), g, r,
                       $urandom(), ($urandom_range(0, 1) == 1));
        end

        run_access(1'b1, 9'h044, 32'h0, 3'd2, 0, 0, 32'hCAFEF00D, 1'b0);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        addr      = 9'h040;
        func3     = 3'd2;
        @(posedge clk);
        #1;
        ram_gnt = 1'b1;
        @(posedge clk);
        #1;
        ram_gnt = 1'b0;
        @(negedge clk);
        check_val("wait_stall", stall, 1'b1);
        check_val("wait_req", ram_req, 1'b0);
        reset    = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_wait_rd", rd_data, 32'h0);
        check_val("rst_wait_ctl", {28'h0, stall, ram_req, misalign, access_err}, 32'h0);
        check_val("rst_wait_be", {25'h0, ram_addr}, 32'h0);
        check_val("rst_wait_wd", ram_wdata, 32'h0);
        check_val("rst_wait_bemask", {28'h0, ram_be}, 32'h0);
        ram_rvalid = 1'b1;
        ram_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        ram_rvalid = 1'b0;
        @(negedge clk);
        check_val("late_rvalid_rd", rd_data, 32'h0);
        check_val("late_rvalid_stall", stall, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Load/store bridge between the pipeline's MEM stage and a variable-latency, word-wide data RAM port. Takes the EX/MEM access (read/write, byte address, store data, func3), performs byte-lane steering and sign/zero extension, runs a request/grant/response handshake with the RAM, and holds the pipeline with `stall` until the access completes. Misaligned accesses, illegal func3 values and RAM timeouts are flagged and never reach memory.

## Interface
- `DATA_W`, 32: data width; only 32 is supported.
- `DM_ADDRESS`, 9: byte-address width.
- `TIMEOUT_CYC`, 16: max cycles spent in REQ+WAIT before abort; must be ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `mem_read` in 1: load present in MEM stage.
- `mem_write` in 1: store present in MEM stage. The pipeline never asserts `mem_read` and `mem_write` together.
- `addr` in DM_ADDRESS: byte address.
- `wr_data` in DATA_W: store data, right-aligned.
- `func3` in 3: access size and sign.
- `rd_data` out DATA_W: extended load result. Registered; reset value 0.
- `stall` out 1: freeze IF/ID/EX/MEM. Combinational from state and inputs.
- `misalign` out 1: one-cycle pulse. Registered; reset value 0.
- `access_err` out 1: one-cycle pulse on illegal func3 or timeout. Registered; reset value 0.
- `ram_req` out 1: request valid. Reset value 0.
- `ram_we` out 1: write request. Reset value 0.
- `ram_addr` out DM_ADDRESS-2: word address, `addr[DM_ADDRESS-1:2]`. Reset value 0.
- `ram_be` out 4: byte enables. Reset value 0.
- `ram_wdata` out DATA_W: lane-replicated store data. Reset value 0.
- `ram_gnt` in 1: request accepted.
- `ram_rvalid` in 1: read data valid.
- `ram_rdata` in DATA_W: read word.

## Operation

**Legal func3 values**
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other value is illegal.

**Alignment**
- Halfword is misaligned when `addr[0]` = 1.
- Word is misaligned when `addr[1:0]` ≠ 0.

**Check order**
- Illegal func3 is checked first, then alignment.
- Error in IDLE: pulse `access_err` or `misalign` on the next cycle, issue no RAM access, assert no stall, leave `rd_data` unchanged.

**Byte enables**
- Byte access: `ram_be` = 0001 shifted left by `addr[1:0]`.
- Halfword access: `ram_be` = 0011 shifted left by `addr[1]`×2.
- Word access: `ram_be` = 1111.

**Store data**
- SB: `ram_wdata` = four copies of `wr_data[7:0]`.
- SH: two copies of `wr_data[15:0]`.
- SW: `wr_data` unchanged.

**Load data**
- Select the byte lane or halfword lane from `ram_rdata` using the latched `addr[1:0]`.
- Sign-extend for LB/LH; zero-extend for LBU/LHU.

**FSM**

IDLE:
- Legal access presented: `stall`=1 combinationally; latch addr, be, wdata, func3 and direction; go to REQ.
- Otherwise stay in IDLE.

REQ:
- `ram_req`=1; `ram_addr`, `ram_be`, `ram_wdata` and `ram_we` driven from the latches; `stall`=1.
- On `ram_gnt`: a store goes to DONE, a load goes to WAIT.

WAIT:
- `stall`=1.
- On `ram_rvalid`: register the extended data into `rd_data` and go to DONE.
- `ram_rvalid` is sampled only in WAIT; the RAM must not return data in the same cycle as `ram_gnt`.

DONE:
- `stall`=0, so the pipeline advances at this edge; go to IDLE.
- Inputs are ignored in DONE; the access still shown on them is the one just completed.

**Timeout**
- A counter clears on IDLE→REQ and increments in REQ and WAIT.
- When it reaches TIMEOUT_CYC−1 without the awaited `ram_gnt`/`ram_rvalid`: drop `ram_req`, load `rd_data`=0, pulse `access_err`, go to DONE.

**Reset**
- Returns to IDLE from any state and clears all registered outputs.
- A `ram_rvalid` that arrives after reset is ignored.

## Timing
- Load with `ram_gnt` in the first REQ cycle and `ram_rvalid` one cycle later: `stall` high for 3 cycles (IDLE, REQ, WAIT). `rd_data` is valid from the DONE cycle and holds until the next load completes.
- Store with immediate `ram_gnt`: `stall` high for 2 cycles (IDLE, REQ).
- Each extra cycle of `ram_gnt`/`ram_rvalid` delay adds one stall cycle.
- Back-to-back accesses: a new access is accepted in the IDLE cycle immediately after DONE. There are no dead cycles beyond DONE.

## Structure
- Shared pipeline package holds:
  - `lsu_state_e` enum (IDLE, REQ, WAIT, DONE);
  - func3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`;
  - a `lsu_req_t` struct for the latched request.
- One combinational sub-module, `lsu_align`, computes be, wdata replication, load extraction/extension and the misalign/illegal flags.
- The FSM, latches and timeout counter stay in `lsu_mem_bridge`.

## Test plan
- SW: addr 0x010, wr_data 0xDEADBEEF, `ram_gnt` immediate → `ram_addr`=0x04, `ram_be`=1111, `ram_wdata`=0xDEADBEEF, `stall` high exactly 2 cycles.
- SB: addr 0x013, wr_data 0x000000A5 → `ram_be`=1000, `ram_wdata`=0xA5A5A5A5.
- LB then LBU at addr 0x022 with `ram_rdata`=0x1280FF00 → `rd_data`=0xFFFFFF80, then 0x00000080. LH at 0x022 → 0x00001280. Stall is 3 cycles each.
- LW at addr 0x006 → `misalign` pulses 1 cycle, `ram_req` never asserts, `stall` stays 0, `rd_data` unchanged. func3=011 → `access_err` pulses instead.
- LW with `ram_gnt` held low, TIMEOUT_CYC=16 → `stall` high 17 cycles (IDLE + 16), then `access_err` pulses and `rd_data`=0.
- Reset asserted while in WAIT → next cycle: IDLE, `ram_req`=0, all outputs 0. A later `ram_rvalid` leaves `rd_data` at 0.
